// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes, direction encoding and decoder FSM states shared by the PS/2 input path
package ps2_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  typedef enum logic [1:0] {DIR_LEFT = 2'd0, DIR_DOWN = 2'd1, DIR_UP = 2'd2, DIR_RIGHT = 2'd3} dir_e;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;
  function automatic logic is_arrow(input logic [7:0] b);
    return b == SC_LEFT || b == SC_DOWN || b == SC_UP || b == SC_RIGHT;
  endfunction
  function automatic dir_e arrow_dir(input logic [7:0] b);
    return b == SC_LEFT ? DIR_LEFT : b == SC_DOWN ? DIR_DOWN : b == SC_UP ? DIR_UP : DIR_RIGHT;
  endfunction
endpackage

// File: rtl/ps2_prefix_timer.sv
// ps2_prefix_timer: clear/enable down-counter that pulses expired after TIMEOUT enabled cycles
module ps2_prefix_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);
  logic [W-1:0] cnt;
  assign expired = enable && !clear && cnt == '0;
  always_ff @(posedge clock)
    if (reset || clear || expired) cnt <= LOAD;
    else if (enable) cnt <= cnt - 1'b1;
endmodule

// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder: decodes extended arrow make/break bytes into one-at-a-time move pulses and direction
module ps2_arrow_decoder
  import ps2_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 100000,
  parameter bit REPEAT_EN      = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       move,
  output logic [1:0] dir,
  output logic       key_held,
  output logic       seq_error
);
  state_e state, state_n;
  logic [7:0] held_code;
  logic timeout, make, release_hit, accept;
  ps2_prefix_timer #(.TIMEOUT(PREFIX_TIMEOUT)) u_timer (
    .clock,
    .reset,
    .clear(received_data_en || state == IDLE),
    .enable(state != IDLE),
    .expired(timeout)
  );
  always_comb begin
    state_n = state;
    make = 1'b0;
    release_hit = 1'b0;
    if (received_data_en)
      case (state)
        IDLE: state_n = received_data == SC_EXT ? EXT : received_data == SC_BRK ? BRK : IDLE;
        EXT: begin
          state_n = received_data == SC_EXT ? EXT : received_data == SC_BRK ? EXT_BRK : IDLE;
          make = is_arrow(received_data);
        end
        EXT_BRK: begin
          state_n = IDLE;
          release_hit = key_held && received_data == held_code;
        end
        default: state_n = IDLE;
      endcase
    else if (timeout) state_n = IDLE;
  end
  assign accept = make && (!key_held || (REPEAT_EN && received_data == held_code));
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock)
    if (reset) begin
      move <= 1'b0;
      dir <= '0;
      key_held <= 1'b0;
      seq_error <= 1'b0;
      held_code <= '0;
    end else begin
      move <= accept;
      seq_error <= timeout;
      if (make && !key_held) begin
        held_code <= received_data;
        key_held <= 1'b1;
        dir <= arrow_dir(received_data);
      end else if (release_hit) begin
        key_held <= 1'b0;
        held_code <= '0;
      end
    end
endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// tb_ps2_arrow_decoder: directed byte vectors against a no-repeat and a repeat instance
module tb_ps2_arrow_decoder;
  logic clock = 1'b0, reset = 1'b1, received_data_en = 1'b0;
  logic [7:0] received_data = '0;
  logic move_a, move_b, held_a, held_b, err_a, err_b;
  logic [1:0] dir_a, dir_b;
  int tests = 0, fails = 0, moves_a = 0, moves_b = 0, errs_a = 0, errs_b = 0;
  int exp_moves_a = 0, exp_moves_b = 0, first_err;
  typedef struct {
    logic [7:0] b;
    int gap;
    logic m_a, m_b;
    logic [1:0] d;
    logic h;
  } vec_t;
  vec_t v[$];

  always #5 clock = ~clock;

  ps2_arrow_decoder #(.PREFIX_TIMEOUT(16), .REPEAT_EN(1'b0)) u_a (
    .clock(clock), .reset(reset), .received_data(received_data), .received_data_en(received_data_en),
    .move(move_a), .dir(dir_a), .key_held(held_a), .seq_error(err_a));
  ps2_arrow_decoder #(.PREFIX_TIMEOUT(16), .REPEAT_EN(1'b1)) u_b (
    .clock(clock), .reset(reset), .received_data(received_data), .received_data_en(received_data_en),
    .move(move_b), .dir(dir_b), .key_held(held_b), .seq_error(err_b));

  always @(negedge clock) begin
    moves_a += int'(move_a);
    moves_b += int'(move_b);
    errs_a += int'(err_a);
    errs_b += int'(err_b);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    received_data = b;
    received_data_en = 1'b1;
    @(negedge clock);
    received_data_en = 1'b0;
  endtask

  task automatic add(input logic [7:0] b, input logic m_a, input logic m_b, input logic [1:0] d, input logic h);
    vec_t x;
    x.b = b; x.gap = 2; x.m_a = m_a; x.m_b = m_b; x.d = d; x.h = h;
    v.push_back(x);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    add(8'hE0, 0, 0, 0, 0); add(8'h75, 1, 1, 2, 1);
    for (int r = 0; r < 3; r++) begin
      add(8'hE0, 0, 0, 2, 1); add(8'h75, 0, 1, 2, 1);
    end
    add(8'hE0, 0, 0, 2, 1); add(8'h6B, 0, 0, 2, 1);
    add(8'hE0, 0, 0, 2, 1); add(8'hF0, 0, 0, 2, 1); add(8'h75, 0, 0, 2, 0);
    add(8'hE0, 0, 0, 2, 0); add(8'h6B, 1, 1, 0, 1);
    add(8'hE0, 0, 0, 0, 1); add(8'hF0, 0, 0, 0, 1); add(8'h6B, 0, 0, 0, 0);
    add(8'h1C, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0); add(8'h1C, 0, 0, 0, 0);
    add(8'hE0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0); add(8'h74, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_move", move_a, 0);
    chk("reset_dir", dir_a, 0);
    chk("reset_held", held_a, 0);
    chk("reset_err", err_a, 0);
    foreach (v[i]) begin
      send(v[i].b);
      chk($sformatf("v%0d_move_a", i), move_a, v[i].m_a);
      chk($sformatf("v%0d_move_b", i), move_b, v[i].m_b);
      chk($sformatf("v%0d_dir_a", i), dir_a, v[i].d);
      chk($sformatf("v%0d_dir_b", i), dir_b, v[i].d);
      chk($sformatf("v%0d_held_a", i), held_a, v[i].h);
      chk($sformatf("v%0d_held_b", i), held_b, v[i].h);
      exp_moves_a += int'(v[i].m_a);
      exp_moves_b += int'(v[i].m_b);
      repeat (v[i].gap) @(negedge clock);
    end
    // lone E0: error expected 16 cycles after the strobe edge (17th sampling negedge)
    first_err = 0;
    received_data = 8'hE0;
    received_data_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      received_data_en = 1'b0;
      if (err_a && first_err == 0) first_err = k;
    end
    chk("timeout_cycle", first_err, 17);
    chk("timeout_held", held_a, 0);
    send(8'h72);
    chk("after_timeout_move", move_a, 0);
    chk("after_timeout_held", held_a, 0);
    send(8'hE0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    send(8'h72);
    chk("midreset_move", move_a, 0);
    chk("midreset_dir", dir_a, 0);
    chk("midreset_held", held_a, 0);
    chk("midreset_err", err_a, 0);
    repeat (20) @(negedge clock);
    send(8'hE0);
    send(8'h72);
    chk("b2b_move", move_a, 1);
    chk("b2b_dir", dir_a, 1);
    chk("b2b_held", held_a, 1);
    send(8'hE0);
    send(8'hF0);
    send(8'h72);
    chk("b2b_release_held", held_a, 0);
    chk("b2b_release_dir", dir_a, 1);
    // follow-on byte lands exactly on the edge the timeout would fire
    send(8'hE0);
    repeat (15) @(negedge clock);
    send(8'h75);
    chk("prio_move", move_a, 1);
    chk("prio_dir", dir_a, 2);
    chk("prio_err", err_a, 0);
    repeat (30) @(negedge clock);
    chk("prio_no_late_err", errs_a, 1);
    chk("total_moves_a", moves_a, exp_moves_a + 2);
    chk("total_moves_b", moves_b, exp_moves_b + 2);
    chk("total_errs_b", errs_b, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
